// File: rtl/run_accumulator.sv
// rtl/run_accumulator.sv - element-wise sum of RUNS consecutive packets
module run_accumulator #(
  parameter int DATA_WIDTH = 14,
  parameter int BATCH_SIZE = 2048,
  parameter int RUNS       = 3,
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(RUNS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sink_valid,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic [DATA_WIDTH-1:0] sink_data,
  output logic                  source_valid,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic                  source_error,
  output logic [ACC_WIDTH-1:0]  source_data
);

  localparam int IDX_W = $clog2(BATCH_SIZE);
  localparam int RUN_W = (RUNS > 1) ? $clog2(RUNS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH_SIZE - 1);
  localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(RUNS - 1);

  typedef enum logic {WAIT_SOP, IN_PKT} state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d, beat_idx;
  logic [RUN_W-1:0]             run_q, run_d, beat_run;
  logic                         take, abort, last_idx;
  logic signed [DATA_WIDTH-1:0] sample;

  // Stage 1: accepted beat, memory read happens combinationally from here.
  logic                         s1_valid_q, s1_err_q, s1_first_q, s1_last_q;
  logic                         s1_sop_q, s1_eop_q;
  logic [IDX_W-1:0]             s1_addr_q;
  logic signed [ACC_WIDTH-1:0]  s1_data_q;

  logic signed [ACC_WIDTH-1:0]  mem [BATCH_SIZE];
  logic signed [ACC_WIDTH-1:0]  stored, sum;

  assign sample   = sink_data;
  assign last_idx = (idx_q == LAST_IDX);

  // Packet framing: decide whether this beat is data, an abort, or dropped.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    run_d    = run_q;
    take     = 1'b0;
    abort    = 1'b0;
    beat_idx = idx_q;
    beat_run = run_q;
    if (sink_valid) begin
      case (state_q)
        WAIT_SOP: begin
          if (sink_sop) begin
            if (sink_eop) begin
              // A one-beat packet can never be legal, so it cannot start one either.
              abort = 1'b1;
              idx_d = '0;
              run_d = '0;
            end else begin
              take     = 1'b1;
              beat_idx = '0;
              state_d  = IN_PKT;
              idx_d    = IDX_W'(1);
            end
          end
        end
        IN_PKT: begin
          if (sink_sop || (sink_eop != last_idx)) begin
            abort = 1'b1;
            run_d = '0;
            // With a single run the restarting beat would need its own output
            // slot alongside the abort beat, so it is dropped instead.
            if (sink_sop && (RUNS > 1)) begin
              take     = 1'b1;
              beat_idx = '0;
              beat_run = '0;
              state_d  = IN_PKT;
              idx_d    = IDX_W'(1);
            end else begin
              state_d = WAIT_SOP;
              idx_d   = '0;
            end
          end else begin
            take = 1'b1;
            if (last_idx) begin
              state_d = WAIT_SOP;
              idx_d   = '0;
              run_d   = (run_q == LAST_RUN) ? '0 : run_q + RUN_W'(1);
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = WAIT_SOP;
      endcase
    end
  end

  // Framing state plus the stage-1 pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_SOP;
      idx_q      <= '0;
      run_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      run_q      <= run_d;
      s1_valid_q <= take;
      s1_err_q   <= abort && (run_q == LAST_RUN);
      s1_first_q <= (beat_run == '0);
      s1_last_q  <= (beat_run == LAST_RUN);
      s1_sop_q   <= (beat_idx == '0);
      s1_eop_q   <= (beat_idx == LAST_IDX);
      s1_addr_q  <= beat_idx;
      s1_data_q  <= ACC_WIDTH'(sample);
    end
  end

  // The same address recurs at least BATCH_SIZE beats apart, so the write
  // from one beat always lands before the next run reads it.
  assign stored = s1_first_q ? '0 : mem[s1_addr_q];
  assign sum    = stored + s1_data_q;

  // Accumulator storage; not reset because run 0 overwrites every entry.
  always_ff @(posedge clk) begin
    if (s1_valid_q && !s1_last_q) begin
      mem[s1_addr_q] <= sum;
    end
  end

  // Output stage: final-run sums or the abort beat, two cycles after input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= 1'b0;
      source_data  <= '0;
    end else begin
      source_valid <= (s1_valid_q && s1_last_q) || s1_err_q;
      source_sop   <= s1_valid_q && s1_last_q && s1_sop_q;
      source_eop   <= (s1_valid_q && s1_last_q && s1_eop_q) || s1_err_q;
      source_error <= s1_err_q;
      source_data  <= (s1_valid_q && s1_last_q) ? sum : '0;
    end
  end

endmodule
